imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate-extension unit: the successor to the combinational extender.
//  Widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero, sign, upper (LUI) or branch offset (sign, <<2).
//  Registers the result behind a valid/ready skid buffer, so the decode->execute boundary sustains 1 result/cycle
//  without a combinational ready path through execute.
// PARAMETERS
//  IN_W   16  immediate input width; legal range IN_W >= 2
//  OUT_W  32  extended output width; must satisfy OUT_W >= IN_W + 2
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  flush      in   1      synchronous pipeline flush (branch/exception squash)
//  in_valid   in   1      input immediate/mode valid
//  in_ready   out  1      unit can accept this cycle
//  imm_in     in   IN_W   raw immediate field
//  mode       in   2      00 zero-ext, 01 sign-ext, 10 upper, 11 branch offset
//  out_valid  out  1      imm_out holds a valid result
//  out_ready  in   1      downstream accepts imm_out this cycle
//  imm_out    out  OUT_W  extended immediate
//  out_count  out  32     accepted-output counter; port exists only with IMM_EXT_PERF_EN
// BEHAVIOUR
//  Extension function (ext) per mode:
//  - 00: {(OUT_W-IN_W){1'b0}, imm}
//  - 01: {(OUT_W-IN_W){imm[IN_W-1]}, imm}
//  - 10: {imm, (OUT_W-IN_W){1'b0}}
//  - 11: sign-extend, then shift left 2; bits shifted past OUT_W-1 are discarded.
//  Storage: output register (out_v, out_d) plus one skid entry (sk_v, sk_d); ext is computed at the input.
//  Handshakes:
//  - in_ready = !sk_v && !rst (combinational from state only).
//  - Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
//  - in_valid, imm_in and mode must stay stable while in_valid && !in_ready.
//  Each posedge, in priority order:
//  1. rst or flush: out_v <= 0, sk_v <= 0; out_d and sk_d are cleared to 0. Any same-cycle accept is dropped.
//  2. !out_v || out_ready:
//     - sk_v=1: out_d <= sk_d, out_v <= 1, sk_v <= 0. No accept is possible (in_ready=0).
//     - sk_v=0: out_v <= accept; if accept, out_d <= ext(imm_in, mode).
//  3. else (stalled): if accept, sk_d <= ext(...) and sk_v <= 1.
//  Timing and ordering:
//  - Latency is 1 cycle: an input accepted at edge N appears with out_valid=1 after edge N.
//  - Full throughput with out_ready=1. Strict FIFO order; no duplication or loss, except on flush/reset.
//  - Full condition (out_v && sk_v) deasserts in_ready. It reasserts the cycle after the first output transfer.
//  - out_valid is held and imm_out is stable until transfer (AXI-style). out_valid is never withdrawn except by rst/flush.
//  Reset values: out_valid=0, imm_out=0, in_ready=0 during rst and 1 the cycle after, out_count=0.
//  Reset or flush mid-transfer: the pending transfer on that edge is not counted; both entries are discarded.
// CONFIGURATION
//  IMM_EXT_PERF_EN defined:
//  - Adds out_count, a 32-bit counter that increments on each output transfer and wraps 0xFFFFFFFF->0.
//  - Cleared by rst only. flush does not clear it.
//  IMM_EXT_PERF_EN undefined: out_count port and counter logic are absent. All other behaviour is identical.
// TESTING (IN_W=16, OUT_W=32)
//  - Modes, out_ready=1: 0x8000 in modes 00/01/10/11 -> 0x00008000 / 0xFFFF8000 / 0x80000000 / 0xFFFE0000,
//    each 1 cycle after accept; 0xFFFF mode 11 -> 0xFFFFFFFC.
//  - Streaming: 8 back-to-back inputs with out_ready=1 -> 8 outputs on 8 consecutive cycles, in_ready held 1.
//  - Backpressure: out_ready=0, send A=0x0001 and B=0x0002 -> A held on imm_out, in_ready=0.
//    Present C=0x0003 (held). Raise out_ready -> outputs A, B, C in order; in_ready=1 one cycle after A transfers.
//  - Flush when full (out_v=sk_v=1) with in_valid=1 -> next cycle out_valid=0, in_ready=1. A and B never appear.
//  - Reset mid-stream (rst=1 for 1 cycle while out_valid=1) -> out_valid=0, imm_out=0, in_ready=0 during rst;
//    in_ready=1 the following cycle.
//  - PERF_EN: 5 transfers, then flush, then 2 transfers -> out_count=7; rst -> 0. Preloaded 0xFFFFFFFF + 1 transfer -> 0.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//  Pipelined immediate-extension unit. Widens an IN_W-bit immediate to OUT_W
//  bits (zero / sign / upper / branch offset) and presents the result through
//  an output register backed by one skid entry. in_ready depends only on the
//  skid state, so there is no combinational path from out_ready to in_ready.
//
//  Optional feature: define IMM_EXT_PERF_EN to add the 32-bit out_count port,
//  which counts output transfers. It is cleared by rst only, not by flush.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out
`ifdef IMM_EXT_PERF_EN
  ,
  output logic [31:0]      out_count
`endif
);

  // Extension modes: 00 zero, 01 sign, 10 upper (LUI), 11 branch offset.
  function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] imm,
                                           input logic [1:0]      m);
    logic [OUT_W-1:0] sx;
    sx = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (m)
      2'b00:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b01:   ext = sx;
      2'b10:   ext = {imm, {(OUT_W-IN_W){1'b0}}};
      2'b11:   ext = {sx[OUT_W-3:0], 2'b00};
      default: ext = {OUT_W{1'b0}};
    endcase
  endfunction

  logic             r_out_v;
  logic [OUT_W-1:0] r_out_d;
  logic             r_sk_v;
  logic [OUT_W-1:0] r_sk_d;

  logic             w_accept;
  logic             w_xfer;
  logic [OUT_W-1:0] w_ext;

  // Handshake decode; ready is a function of skid occupancy and reset only.
  always_comb begin
    in_ready  = !r_sk_v && !rst;
    w_accept  = in_valid && in_ready;
    w_xfer    = r_out_v && out_ready;
    w_ext     = ext(imm_in, mode);
    out_valid = r_out_v;
    imm_out   = r_out_d;
  end

  // Output register and skid entry: refill from skid first, then from input.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_out_v <= 1'b0;
      r_out_d <= {OUT_W{1'b0}};
      r_sk_v  <= 1'b0;
      r_sk_d  <= {OUT_W{1'b0}};
    end else if (!r_out_v || out_ready) begin
      if (r_sk_v) begin
        r_out_d <= r_sk_d;
        r_out_v <= 1'b1;
        r_sk_v  <= 1'b0;
      end else begin
        r_out_v <= w_accept;
        if (w_accept) begin
          r_out_d <= w_ext;
        end else begin
          r_out_d <= r_out_d;
        end
      end
    end else begin
      if (w_accept) begin
        r_sk_d <= w_ext;
        r_sk_v <= 1'b1;
      end else begin
        r_sk_d <= r_sk_d;
        r_sk_v <= r_sk_v;
      end
    end
  end

`ifdef IMM_EXT_PERF_EN
  logic [31:0] r_out_count;

  // Transfer counter; a transfer on a reset/flush edge is discarded, not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_count <= 32'd0;
    end else if (w_xfer && !flush) begin
      r_out_count <= r_out_count + 32'd1;
    end else begin
      r_out_count <= r_out_count;
    end
  end

  assign out_count = r_out_count;
`else
  logic w_xfer_unused;
  assign w_xfer_unused = w_xfer;
`endif

endmodule
